miriscv_mem_arbiter: RTL and testbench
======================================

# miriscv_mem_arbiter

Two-port to one-port memory arbiter that lets the core's instruction-fetch and data-memory interfaces share a single unified memory bus. It sits between the core's fetch and memory stages and the memory. Each transaction is forwarded only after the memory grants it. A small in-order tag FIFO records which port issued each accepted transaction, so every response is returned to the port that issued it.

## Interface
- XLEN, 32: address/data width.
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered transactions (≥1); sets tag FIFO depth.

- clk_i  in  1  clock; all state updates on the rising edge.
- arst_i  in  1  asynchronous reset, active high.
- instr_req_i  in  1  fetch request; held with payload stable until instr_gnt_o.
- instr_addr_i  in  XLEN  fetch address.
- instr_gnt_o  out  1  fetch request accepted this cycle.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  XLEN  fetch response data.
- data_req_i  in  1  data request; held with payload stable until data_gnt_o.
- data_we_i  in  1  write enable.
- data_be_i  in  XLEN/8  byte enables.
- data_addr_i  in  XLEN  data address.
- data_wdata_i  in  XLEN  write data.
- data_gnt_o  out  1  data request accepted this cycle.
- data_rvalid_o  out  1  data response valid; also asserted for writes.
- data_rdata_o  out  XLEN  data response data.
- mem_req_o  out  1  unified bus request.
- mem_we_o  out  1  bus write enable; 0 for fetches.
- mem_be_o  out  XLEN/8  bus byte enables; all ones for fetches.
- mem_addr_o  out  XLEN  bus address.
- mem_wdata_o  out  XLEN  bus write data; 0 for fetches.
- mem_gnt_i  in  1  memory accepts the current request.
- mem_rvalid_i  in  1  in-order response valid; exactly one per granted transaction.
- mem_rdata_i  in  XLEN  response data.
- err_o  out  1  sticky error: response received with no outstanding transaction.

## Operation
- State: lock_q, lock_src_q, last_q (last granted source), tag FIFO (1 bit per entry: 0 = instr, 1 = data), count_q (width $clog2(MAX_OUTSTANDING+1)), err_q.
- full = (count_q == MAX_OUTSTANDING). When full, mem_req_o = 0 and neither port is granted.
- Source selection, in priority order:
  - If lock_q = 1: select lock_src_q.
  - Else if only one port requests: select that port.
  - Else if both request: select the port ≠ last_q (round-robin).
- mem_req_o = !full and the selected port's request. The mem_* payload is muxed from the selected port.
- Grant:
  - instr_gnt_o = mem_req_o & mem_gnt_i & (sel = instr).
  - data_gnt_o = mem_req_o & mem_gnt_i & (sel = data).
  - Grants are combinational from mem_gnt_i.
- Lock: when mem_req_o & !mem_gnt_i, set lock_q = 1 and lock_src_q = sel. The bus request never changes source or payload before it is granted. The lock clears on grant.
- On a grant: push sel into the FIFO and set last_q = sel.
- Response routing, for mem_rvalid_i with count_q > 0:
  - Pop the FIFO head.
  - Head = 0: instr_rvalid_o = 1. Head = 1: data_rvalid_o = 1.
  - instr_rdata_o = data_rdata_o = mem_rdata_i (pass-through; rvalid qualifies it).
- Spurious response: mem_rvalid_i with count_q = 0 asserts no port rvalid and sets err_q = 1. err_q stays set until reset.
- Grant and response in the same cycle: push and pop both occur and count_q is unchanged. Because a grant cannot occur when full, overflow is impossible. A same-cycle response does not unblock a grant while full; the grant waits one cycle.

## Timing
- Reset values:
  - lock_q = 0, last_q = data (the first tie goes to instr), count_q = 0, FIFO pointers 0, err_q = 0.
  - All outputs 0 while no request is present. mem_be_o follows the mux.
- Request path: zero-cycle combinational, port request to mem_req_o.
- Response path: zero-cycle combinational, mem_rvalid_i to port rvalid.
- Throughput: one transaction per cycle while not full and mem_gnt_i = 1.
- Reset asserted mid-operation: all state clears immediately. Responses to transactions outstanding at reset that arrive later are treated as spurious and set err_o.

## Test plan
- Fetch only, memory latency 1, gnt always 1, addresses 0x0, 0x4, 0x8: one instr_gnt_o per cycle; instr_rvalid_o returns the data one cycle later, in order. data_rvalid_o stays 0.
- Both ports request every cycle, gnt always 1: grants alternate instr, data, instr, data starting with instr. Each response is routed to the matching port.
- Data write requested, gnt low for 3 cycles while instr_req_i rises: mem_req_o holds the data payload (we = 1, be = 0xF, addr/wdata stable) until grant. Instr is granted on the next cycle.
- MAX_OUTSTANDING = 2, gnt always 1, no responses: two grants, then mem_req_o = 0. After one mem_rvalid_i, one further grant occurs on the following cycle.
- mem_rvalid_i pulsed with count_q = 0: no port rvalid; err_o = 1 and stays 1 until arst_i.
- arst_i pulsed with 2 outstanding: count_q = 0 and lock_q = 0. The next tie grants instr.

Source files
------------

// File: rtl/miriscv_mem_arbiter_if.sv
// rtl/miriscv_mem_arbiter_if.sv - fetch/data/memory bus bundle for the two-to-one memory arbiter
interface miriscv_mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic              instr_req_i;
    logic [XLEN-1:0]   instr_addr_i;
    logic              instr_gnt_o;
    logic              instr_rvalid_o;
    logic [XLEN-1:0]   instr_rdata_o;

    logic              data_req_i;
    logic              data_we_i;
    logic [XLEN/8-1:0] data_be_i;
    logic [XLEN-1:0]   data_addr_i;
    logic [XLEN-1:0]   data_wdata_i;
    logic              data_gnt_o;
    logic              data_rvalid_o;
    logic [XLEN-1:0]   data_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [XLEN/8-1:0] mem_be_o;
    logic [XLEN-1:0]   mem_addr_o;
    logic [XLEN-1:0]   mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [XLEN-1:0]   mem_rdata_i;

    logic              err_o;

    // Arbiter side
    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output err_o
    );

    // Core/memory side driving the arbiter
    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  err_o
    );
endinterface

// File: rtl/miriscv_mem_arbiter.sv
// rtl/miriscv_mem_arbiter.sv - round-robin fetch/data to unified memory arbiter with in-order tag FIFO
module miriscv_mem_arbiter #(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    miriscv_mem_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

    localparam logic SRC_INSTR = 1'b0;
    localparam logic SRC_DATA  = 1'b1;

    logic                       lock_q, lock_d;
    logic                       lock_src_q, lock_src_d;
    logic                       last_q, last_d;
    logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       err_q, err_d;

    logic sel;
    logic full;
    logic sel_req;
    logic push;
    logic pop;
    logic head;

    assign full = (count_q == CNT_FULL);
    assign head = tag_q[rd_ptr_q];

    always_comb begin
        sel = ~last_q;
        if (lock_q) begin
            sel = lock_src_q;
        end else if (bus.instr_req_i && !bus.data_req_i) begin
            sel = SRC_INSTR;
        end else if (bus.data_req_i && !bus.instr_req_i) begin
            sel = SRC_DATA;
        end
    end

    assign sel_req       = (sel == SRC_DATA) ? bus.data_req_i : bus.instr_req_i;
    assign bus.mem_req_o = !full && sel_req;

    always_comb begin
        if (sel == SRC_DATA) begin
            bus.mem_we_o    = bus.data_we_i;
            bus.mem_be_o    = bus.data_be_i;
            bus.mem_addr_o  = bus.data_addr_i;
            bus.mem_wdata_o = bus.data_wdata_i;
        end else begin
            bus.mem_we_o    = 1'b0;
            bus.mem_be_o    = '1;
            bus.mem_addr_o  = bus.instr_addr_i;
            bus.mem_wdata_o = '0;
        end
    end

    assign push            = bus.mem_req_o && bus.mem_gnt_i;
    assign bus.instr_gnt_o = push && (sel == SRC_INSTR);
    assign bus.data_gnt_o  = push && (sel == SRC_DATA);

    // A response with nothing outstanding is dropped and only flags the error.
    assign pop               = bus.mem_rvalid_i && (count_q != '0);
    assign bus.instr_rvalid_o = pop && (head == SRC_INSTR);
    assign bus.data_rvalid_o  = pop && (head == SRC_DATA);
    assign bus.instr_rdata_o  = bus.mem_rdata_i;
    assign bus.data_rdata_o   = bus.mem_rdata_i;
    assign bus.err_o          = err_q;

    always_comb begin
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        last_d     = last_q;
        tag_d      = tag_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_d      = err_q;

        // Freeze the source while the bus request waits for the memory.
        if (bus.mem_req_o && !bus.mem_gnt_i) begin
            lock_d     = 1'b1;
            lock_src_d = sel;
        end else if (push) begin
            lock_d = 1'b0;
        end

        if (push) begin
            tag_d[wr_ptr_q] = sel;
            wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            last_d          = sel;
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (bus.mem_rvalid_i && (count_q == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            lock_q     <= 1'b0;
            lock_src_q <= SRC_INSTR;
            last_q     <= SRC_DATA;
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            last_q     <= last_d;
            tag_q      <= tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// tb/tb_miriscv_mem_arbiter.sv - directed table-driven bench for the memory arbiter
module tb_miriscv_mem_arbiter;
    localparam int XLEN = 32;
    localparam int NV   = 10;

    logic clk_i = 1'b0;
    logic arst_i;

    miriscv_mem_arbiter_if #(.XLEN(XLEN)) bus ();

    miriscv_mem_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(2)) dut (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .bus    (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic ir, dr, we, gnt, rv;
        logic mreq, sel, igt, dgt, irv, drv;
    } vec_t;

    vec_t vecs [NV];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic dr, input logic we, input logic gnt,
                         input logic rv, input logic [31:0] iaddr, input logic [31:0] daddr,
                         input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] rdata);
        bus.instr_req_i  = ir;
        bus.instr_addr_i = iaddr;
        bus.data_req_i   = dr;
        bus.data_we_i    = we;
        bus.data_be_i    = be;
        bus.data_addr_i  = daddr;
        bus.data_wdata_i = wdata;
        bus.mem_gnt_i    = gnt;
        bus.mem_rvalid_i = rv;
        bus.mem_rdata_i  = rdata;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        idle();
        arst_i = 1'b1;
        #2;
        check("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        @(negedge clk_i);
        arst_i = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1,0,0,1,0, 1,0,1,0,0,0};
        vecs[1] = '{1,1,0,1,1, 1,1,0,1,1,0};
        vecs[2] = '{1,1,0,1,0, 1,0,1,0,0,0};
        vecs[3] = '{1,1,0,1,1, 0,0,0,0,0,1};
        vecs[4] = '{1,1,1,0,0, 1,1,0,0,0,0};
        vecs[5] = '{1,1,1,0,1, 1,1,0,0,1,0};
        vecs[6] = '{1,1,1,1,0, 1,1,0,1,0,0};
        vecs[7] = '{1,0,0,1,1, 1,0,1,0,0,1};
        vecs[8] = '{0,0,0,1,1, 0,0,0,0,1,0};
        vecs[9] = '{0,0,0,0,0, 0,0,0,0,0,0};

        arst_i = 1'b1;
        idle();
        #12;
        check("reset_mem_req", 32'(bus.mem_req_o), 32'd0);
        check("reset_instr_gnt", 32'(bus.instr_gnt_o), 32'd0);
        check("reset_data_gnt", 32'(bus.data_gnt_o), 32'd0);
        check("reset_instr_rvalid", 32'(bus.instr_rvalid_o), 32'd0);
        check("reset_data_rvalid", 32'(bus.data_rvalid_o), 32'd0);
        check("reset_mem_we", 32'(bus.mem_we_o), 32'd0);
        check("reset_mem_addr", bus.mem_addr_o, 32'd0);
        check("reset_mem_wdata", bus.mem_wdata_o, 32'd0);
        check("reset_err", 32'(bus.err_o), 32'd0);
        @(negedge clk_i);
        arst_i = 1'b0;
        @(negedge clk_i);

        // Table: round-robin, full stall, lock, same-cycle push/pop, in-order routing
        for (int i = 0; i < NV; i++) begin
            logic [31:0] ia, da, wd, rd;
            ia = 32'h100 + 32'(i) * 4;
            da = 32'h2000 + 32'(i) * 4;
            wd = 32'hA5A50000 + 32'(i);
            rd = 32'hD0000000 + 32'(i);
            drive(vecs[i].ir, vecs[i].dr, vecs[i].we, vecs[i].gnt, vecs[i].rv, ia, da, wd, 4'h3, rd);
            #2;
            check($sformatf("v%0d_mem_req", i), 32'(bus.mem_req_o), 32'(vecs[i].mreq));
            check($sformatf("v%0d_instr_gnt", i), 32'(bus.instr_gnt_o), 32'(vecs[i].igt));
            check($sformatf("v%0d_data_gnt", i), 32'(bus.data_gnt_o), 32'(vecs[i].dgt));
            check($sformatf("v%0d_instr_rvalid", i), 32'(bus.instr_rvalid_o), 32'(vecs[i].irv));
            check($sformatf("v%0d_data_rvalid", i), 32'(bus.data_rvalid_o), 32'(vecs[i].drv));
            if (vecs[i].mreq) begin
                check($sformatf("v%0d_mem_addr", i), bus.mem_addr_o, vecs[i].sel ? da : ia);
                check($sformatf("v%0d_mem_we", i), 32'(bus.mem_we_o), vecs[i].sel ? 32'(vecs[i].we) : 32'd0);
                check($sformatf("v%0d_mem_be", i), 32'(bus.mem_be_o), vecs[i].sel ? 32'h3 : 32'hF);
                check($sformatf("v%0d_mem_wdata", i), bus.mem_wdata_o, vecs[i].sel ? wd : 32'd0);
            end
            if (vecs[i].irv) check($sformatf("v%0d_instr_rdata", i), bus.instr_rdata_o, rd);
            if (vecs[i].drv) check($sformatf("v%0d_data_rdata", i), bus.data_rdata_o, rd);
            check($sformatf("v%0d_err", i), 32'(bus.err_o), 32'd0);
            next_cycle();
        end

        // Lock: data write stalls 3 cycles while fetch rises; payload must not switch
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(c > 0, 1, 1, 0, 0, 32'h40, 32'h3000, 32'hCAFEF00D, 4'hF, 32'h0);
            #2;
            check($sformatf("lock%0d_mem_req", c), 32'(bus.mem_req_o), 32'd1);
            check($sformatf("lock%0d_mem_addr", c), bus.mem_addr_o, 32'h3000);
            check($sformatf("lock%0d_mem_we", c), 32'(bus.mem_we_o), 32'd1);
            check($sformatf("lock%0d_mem_be", c), 32'(bus.mem_be_o), 32'hF);
            check($sformatf("lock%0d_mem_wdata", c), bus.mem_wdata_o, 32'hCAFEF00D);
            check($sformatf("lock%0d_instr_gnt", c), 32'(bus.instr_gnt_o), 32'd0);
            next_cycle();
        end
        drive(1, 1, 1, 1, 0, 32'h40, 32'h3000, 32'hCAFEF00D, 4'hF, 32'h0);
        #2;
        check("lock_release_data_gnt", 32'(bus.data_gnt_o), 32'd1);
        check("lock_release_instr_gnt", 32'(bus.instr_gnt_o), 32'd0);
        next_cycle();
        drive(1, 0, 0, 1, 0, 32'h40, 32'h0, 32'h0, 4'h0, 32'h0);
        #2;
        check("after_lock_instr_gnt", 32'(bus.instr_gnt_o), 32'd1);
        check("after_lock_mem_addr", bus.mem_addr_o, 32'h40);
        next_cycle();
        drive(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 4'h0, 32'h11111111);
        #2;
        check("lock_resp1_data_rvalid", 32'(bus.data_rvalid_o), 32'd1);
        check("lock_resp1_instr_rvalid", 32'(bus.instr_rvalid_o), 32'd0);
        next_cycle();
        drive(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 4'h0, 32'h22222222);
        #2;
        check("lock_resp2_instr_rvalid", 32'(bus.instr_rvalid_o), 32'd1);
        check("lock_resp2_instr_rdata", bus.instr_rdata_o, 32'h22222222);
        next_cycle();

        // Spurious response sets a sticky error
        drive(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 4'h0, 32'h5);
        #2;
        check("spur_instr_rvalid", 32'(bus.instr_rvalid_o), 32'd0);
        check("spur_data_rvalid", 32'(bus.data_rvalid_o), 32'd0);
        next_cycle();
        idle();
        for (int c = 0; c < 3; c++) begin
            #2;
            check($sformatf("err_sticky%0d", c), 32'(bus.err_o), 32'd1);
            next_cycle();
        end

        // Reset with one outstanding fetch and a data request locked behind a low grant
        drive(1, 0, 0, 1, 0, 32'h80, 32'h0, 32'h0, 4'h0, 32'h0);
        next_cycle();
        drive(1, 1, 0, 0, 0, 32'h80, 32'h4000, 32'h0, 4'hF, 32'h0);
        #2;
        check("prerst_sel_data", bus.mem_addr_o, 32'h4000);
        next_cycle();
        do_reset();
        drive(1, 1, 0, 1, 0, 32'h84, 32'h4000, 32'h0, 4'hF, 32'h0);
        #2;
        check("postrst_err", 32'(bus.err_o), 32'd0);
        check("postrst_tie_instr_gnt", 32'(bus.instr_gnt_o), 32'd1);
        check("postrst_tie_data_gnt", 32'(bus.data_gnt_o), 32'd0);
        next_cycle();
        drive(1, 1, 0, 1, 0, 32'h88, 32'h4000, 32'h0, 4'hF, 32'h0);
        #2;
        check("postrst_second_data_gnt", 32'(bus.data_gnt_o), 32'd1);
        next_cycle();
        drive(1, 1, 0, 1, 0, 32'h8C, 32'h4000, 32'h0, 4'hF, 32'h0);
        #2;
        check("postrst_full_mem_req", 32'(bus.mem_req_o), 32'd0);
        next_cycle();
        drive(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        next_cycle();
        drive(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        next_cycle();
        drive(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        #2;
        check("late_resp_no_rvalid", 32'(bus.instr_rvalid_o | bus.data_rvalid_o), 32'd0);
        next_cycle();
        idle();
        #2;
        check("late_resp_err", 32'(bus.err_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
